clint_multihart: RTL and testbench
==================================

CLINT_MULTIHART -- requirements
Module: clint_multihart

Interface
REQ-001 NUM_HARTS, 1, number of harts served (1..4).
REQ-002 BASE_ADDR, 32'h0200_0000, base of 64 KiB register window.
REQ-003 TICK_DIV, 1, clk cycles per mtime increment (1..65535).
REQ-004 clk  input  1  clock, all state on rising edge.
REQ-005 resetn  input  1  reset, asynchronous, active-low.
REQ-006 awvalid  input  1  write address valid.
REQ-007 awready  output  1  write address accepted.
REQ-008 awaddr  input  32  write byte address.
REQ-009 wvalid  input  1  write data valid.
REQ-010 wready  output  1  write data accepted.
REQ-011 wdata  input  32  write data.
REQ-012 wstrb  input  4  write byte enables.
REQ-013 bvalid  output  1  write response valid.
REQ-014 bready  input  1  write response accepted.
REQ-015 bresp  output  2  00 OKAY, 10 SLVERR.
REQ-016 arvalid  input  1  read address valid.
REQ-017 arready  output  1  read address accepted.
REQ-018 araddr  input  32  read byte address.
REQ-019 rvalid  output  1  read data valid.
REQ-020 rready  input  1  read data accepted.
REQ-021 rdata  output  32  read data.
REQ-022 rresp  output  2  00 OKAY, 10 SLVERR.
REQ-023 mtip  output  NUM_HARTS  per-hart timer interrupt pending.
REQ-024 msip  output  NUM_HARTS  per-hart software interrupt pending.

Function
REQ-025 Offsets from BASE_ADDR: msip[h] 0x0000+4h (bit0 only, other bits read 0); mtimecmp[h] lo 0x4000+8h, hi 0x4004+8h; mtime lo 0xBFF8, hi 0xBFFC; anything else, or h>=NUM_HARTS, is unmapped.
REQ-026 Address decode uses awaddr/araddr[31:2]; low two bits ignored.
REQ-027 Write accept: awready=wready=awvalid&&wvalid&&!bvalid (combinational, same cycle, both channels together); register updated on accept edge.
REQ-028 bvalid rises the cycle after accept, holds with stable bresp until bready; cleared on the bready&&bvalid edge; next accept possible that same cycle only if bvalid is already low, i.e. one write per two cycles minimum.
REQ-029 Read accept: arready=!rvalid; on arvalid&&arready, rdata/rresp register next cycle with rvalid=1, held stable until rready; rdata sampled from state at accept edge.
REQ-030 Unmapped access: SLVERR, no state change, rdata=0.
REQ-031 wstrb[i] enables byte i; wstrb=0 on a mapped address is OKAY with no change.
REQ-032 Prescaler counts 0..TICK_DIV-1, wraps; mtime increments by 1 on each wrap (every clk when TICK_DIV=1); mtime wraps 2^64-1 -> 0.
REQ-033 A write to mtime lo/hi in the same cycle as a tick takes priority: written bytes take wdata, unwritten bytes keep pre-increment value, increment dropped; prescaler reset to 0.
REQ-034 mtip[h]=(mtime>=mtimecmp[h]) unsigned 64-bit, combinational from registers; msip[h]=msip register bit0.
REQ-035 Read and write in the same cycle are independent; read of a register being written returns the old value.

Reset
REQ-036 On resetn low, immediately: mtime=0, prescaler=0, mtimecmp[*]=64'hFFFF_FFFF_FFFF_FFFF, msip=0, mtip=0, bvalid=0, rvalid=0, bresp=00, rresp=00, rdata=0; an in-flight transaction is discarded without response.

Verification
REQ-037 TICK_DIV=1, read 0xBFF8 after 10 cycles from reset release -> OKAY, rdata within 10..12, increasing on re-read.
REQ-038 Write mtimecmp[0] lo=20, hi=0 -> mtip[0] low until mtime>=20, then high in same cycle; write hi=1 -> mtip[0] drops.
REQ-039 NUM_HARTS=2, write 0x0004=1 -> msip=2'b10; write with wstrb=0 -> msip unchanged, bresp=00.
REQ-040 Read 0x1000 and 0x0008 (NUM_HARTS=2) -> rresp=10, rdata=0; write 0x1000 -> bresp=10, no state change.
REQ-041 Hold bready=0 for 5 cycles after write -> bvalid stays 1, awready=wready=0, second write not accepted until bready.
REQ-042 TICK_DIV=4, write mtime lo=0xFFFF_FFFF hi=0 -> after 4 cycles hi=1, lo=0; assert resetn low mid-read -> rvalid=0 immediately, mtime=0.

Source files
------------

// File: rtl/clint_multihart.sv
// Core-local interruptor for up to four harts: a free-running 64-bit mtime
// with a programmable prescaler, per-hart mtimecmp and msip registers, and a
// minimal single-beat AXI4-Lite slave port for register access.
module clint_multihart #(
    parameter int unsigned NUM_HARTS = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 awvalid,
    output logic                 awready,
    input  logic [31:0]          awaddr,
    input  logic                 wvalid,
    output logic                 wready,
    input  logic [31:0]          wdata,
    input  logic [3:0]           wstrb,
    output logic                 bvalid,
    input  logic                 bready,
    output logic [1:0]           bresp,
    input  logic                 arvalid,
    output logic                 arready,
    input  logic [31:0]          araddr,
    output logic                 rvalid,
    input  logic                 rready,
    output logic [31:0]          rdata,
    output logic [1:0]           rresp,
    output logic [NUM_HARTS-1:0] mtip,
    output logic [NUM_HARTS-1:0] msip
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        REG_NONE, REG_MSIP, REG_CMP_LO, REG_CMP_HI, REG_TIME_LO, REG_TIME_HI
    } reg_sel_e;

    typedef struct packed {
        reg_sel_e   sel;
        logic [1:0] hart;
    } decode_t;

    // Map a word address onto a register; anything outside the window or
    // beyond the configured hart count decodes to REG_NONE.
    function automatic decode_t decode(input logic [29:0] word_addr);
        logic [29:0] off_w;
        decode_t     d;
        off_w  = word_addr - BASE_ADDR[31:2];
        d.sel  = REG_NONE;
        d.hart = 2'b00;
        if (off_w[29:14] == 16'h0) begin
            if (off_w[13:0] < 14'(NUM_HARTS)) begin
                d.sel  = REG_MSIP;
                d.hart = off_w[1:0];
            end else if (off_w[13:0] >= 14'h1000 &&
                         off_w[13:0] <  14'h1000 + 14'(2 * NUM_HARTS)) begin
                d.sel  = off_w[0] ? REG_CMP_HI : REG_CMP_LO;
                d.hart = off_w[2:1];
            end else if (off_w[13:0] == 14'h2FFE) begin
                d.sel = REG_TIME_LO;
            end else if (off_w[13:0] == 14'h2FFF) begin
                d.sel = REG_TIME_HI;
            end
        end
        return d;
    endfunction

    // Byte-lane merge of write data into an existing 32-bit word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

    logic [PW-1:0]        presc_q, presc_d;
    logic [63:0]          mtime_q, mtime_d;
    logic [63:0]          cmp_q [NUM_HARTS];
    logic [63:0]          cmp_d [NUM_HARTS];
    logic [NUM_HARTS-1:0] msip_q, msip_d;
    logic                 bvalid_q, rvalid_q;
    logic [1:0]           bresp_q, rresp_q;
    logic [31:0]          rdata_q;

    logic        wr_fire, rd_fire, time_wr, tick;
    decode_t     wr_dec, rd_dec;
    logic [31:0] rd_data;
    logic        rd_err;
    logic        unused_addr_lsbs;

    // Byte offset bits carry no meaning for word-sized registers.
    assign unused_addr_lsbs = ^{awaddr[1:0], araddr[1:0]};

    assign wr_dec  = decode(awaddr[31:2]);
    assign rd_dec  = decode(araddr[31:2]);
    assign wr_fire = awvalid && wvalid && !bvalid_q;
    assign awready = wr_fire;
    assign wready  = wr_fire;
    assign rd_fire = arvalid && !rvalid_q;
    assign arready = !rvalid_q;
    assign time_wr = wr_fire && (wstrb != 4'b0000) &&
                     (wr_dec.sel == REG_TIME_LO || wr_dec.sel == REG_TIME_HI);

    // Prescaler and mtime next state; a bus write to mtime overrides the tick.
    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        tick    = (presc_q == PW'(TICK_DIV - 1));
        presc_d = tick ? '0 : presc_q + PW'(1);
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        if (time_wr) begin
            presc_d = '0;
            mtime_d = mtime_q;
            if (wr_dec.sel == REG_TIME_LO) begin
                mtime_d[31:0]  = merge_bytes(mtime_q[31:0], wdata, wstrb);
            end else begin
                mtime_d[63:32] = merge_bytes(mtime_q[63:32], wdata, wstrb);
            end
        end
    end

    // Per-hart msip / mtimecmp next state from accepted writes.
    always_comb begin
        msip_d = msip_q;
        for (int h = 0; h < NUM_HARTS; h++) begin
            cmp_d[h] = cmp_q[h];
            if (wr_fire && wr_dec.hart == 2'(h)) begin
                case (wr_dec.sel)
                    REG_MSIP:   if (wstrb[0]) msip_d[h] = wdata[0];
                    REG_CMP_LO: cmp_d[h][31:0]  = merge_bytes(cmp_q[h][31:0], wdata, wstrb);
                    REG_CMP_HI: cmp_d[h][63:32] = merge_bytes(cmp_q[h][63:32], wdata, wstrb);
                    default: ;
                endcase
            end
        end
    end

    // Read data mux, sampled from current register state.
    always_comb begin
        rd_data = 32'h0;
        rd_err  = 1'b0;
        case (rd_dec.sel)
            REG_NONE:    rd_err  = 1'b1;
            REG_TIME_LO: rd_data = mtime_q[31:0];
            REG_TIME_HI: rd_data = mtime_q[63:32];
            default: begin
                for (int h = 0; h < NUM_HARTS; h++) begin
                    if (rd_dec.hart == 2'(h)) begin
                        if (rd_dec.sel == REG_MSIP)        rd_data = {31'h0, msip_q[h]};
                        else if (rd_dec.sel == REG_CMP_LO) rd_data = cmp_q[h][31:0];
                        else                               rd_data = cmp_q[h][63:32];
                    end
                end
            end
        endcase
    end

    // Interrupt outputs derived directly from the registers.
    always_comb begin
        mtip = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            mtip[h] = (mtime_q >= cmp_q[h]);
        end
        msip = msip_q;
    end

    // Architectural timer and interrupt registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc_q <= '0;
            mtime_q <= 64'h0;
            msip_q  <= '0;
            // NOTE: the small mtimecmp array is real architectural state with a
            // defined reset value, so it is reset like any other flop.
            for (int h = 0; h < NUM_HARTS; h++) cmp_q[h] <= '1;
        end else begin
            // NOTE: non-blocking so all flops update from pre-edge values.
            presc_q <= presc_d;
            mtime_q <= mtime_d;
            msip_q  <= msip_d;
            for (int h = 0; h < NUM_HARTS; h++) cmp_q[h] <= cmp_d[h];
        end
    end

    // Write response channel: one response per accepted write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else if (wr_fire) begin
            bvalid_q <= 1'b1;
            bresp_q  <= (wr_dec.sel == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
        end else if (bvalid_q && bready) begin
            bvalid_q <= 1'b0;
        end
    end

    // Read data channel: capture on accept, hold until taken.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= 32'h0;
        end else if (rd_fire) begin
            rvalid_q <= 1'b1;
            rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            rdata_q  <= rd_data;
        end else if (rvalid_q && rready) begin
            rvalid_q <= 1'b0;
        end
    end

    assign bvalid = bvalid_q;
    assign bresp  = bresp_q;
    assign rvalid = rvalid_q;
    assign rresp  = rresp_q;
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_clint_multihart.sv
// Directed bench: instance A (2 harts, TICK_DIV=1) and instance B (1 hart,
// TICK_DIV=4) share one bus driver; 'sel' chooses which instance is addressed.
module tb_clint_multihart;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        sel;
    logic        awvalid, wvalid, arvalid, bready, rready;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;

    logic        awready_a, wready_a, bvalid_a, arready_a, rvalid_a;
    logic        awready_b, wready_b, bvalid_b, arready_b, rvalid_b;
    logic [1:0]  bresp_a, rresp_a, bresp_b, rresp_b;
    logic [31:0] rdata_a, rdata_b;
    logic [1:0]  mtip_a, msip_a;
    logic [0:0]  mtip_b, msip_b;

    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign awready = sel ? awready_b : awready_a;
    assign wready  = sel ? wready_b  : wready_a;
    assign bvalid  = sel ? bvalid_b  : bvalid_a;
    assign bresp   = sel ? bresp_b   : bresp_a;
    assign arready = sel ? arready_b : arready_a;
    assign rvalid  = sel ? rvalid_b  : rvalid_a;
    assign rdata   = sel ? rdata_b   : rdata_a;
    assign rresp   = sel ? rresp_b   : rresp_a;

    clint_multihart #(.NUM_HARTS(2), .BASE_ADDR(BASE), .TICK_DIV(1)) u_dut_a (
        .clk(clk), .resetn(resetn),
        .awvalid(awvalid && !sel), .awready(awready_a), .awaddr(awaddr),
        .wvalid(wvalid && !sel), .wready(wready_a), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid_a), .bready(bready), .bresp(bresp_a),
        .arvalid(arvalid && !sel), .arready(arready_a), .araddr(araddr),
        .rvalid(rvalid_a), .rready(rready), .rdata(rdata_a), .rresp(rresp_a),
        .mtip(mtip_a), .msip(msip_a)
    );

    clint_multihart #(.NUM_HARTS(1), .BASE_ADDR(BASE), .TICK_DIV(4)) u_dut_b (
        .clk(clk), .resetn(resetn),
        .awvalid(awvalid && sel), .awready(awready_b), .awaddr(awaddr),
        .wvalid(wvalid && sel), .wready(wready_b), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid_b), .bready(bready), .bresp(bresp_b),
        .arvalid(arvalid && sel), .arready(arready_b), .araddr(araddr),
        .rvalid(rvalid_b), .rready(rready), .rdata(rdata_b), .rresp(rresp_b),
        .mtip(mtip_b), .msip(msip_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One write transaction; acc_cyc is the cycle count right after the accept edge.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp,
                             output int acc_cyc);
        int n;
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        #1;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); #1; n++; end
        check("aw_accept", awready, 1);
        @(posedge clk); #1;
        acc_cyc = cyc;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        check("b_valid", bvalid, 1);
        resp = bresp;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    // One read transaction; data was sampled from state before edge acc_cyc.
    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output int acc_cyc);
        int n;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1;
        #1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); #1; n++; end
        check("ar_accept", arready, 1);
        @(posedge clk); #1;
        acc_cyc = cyc;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        check("r_valid", rvalid, 1);
        data = rdata; resp = rresp;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    initial begin
        logic [31:0] d, d_prev;
        logic [1:0]  r;
        logic [63:0] model;
        int          acc, c0;

        resetn = 1'b0; sel = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;

        // Reset state.
        repeat (3) @(posedge clk); #1;
        check("rst_mtip_a", mtip_a, 0);
        check("rst_msip_a", msip_a, 0);
        check("rst_mtip_b", mtip_b, 0);
        check("rst_bvalid", bvalid_a, 0);
        check("rst_rvalid", rvalid_a, 0);
        check("rst_rdata",  rdata_a, 0);
        check("rst_bresp",  bresp_a, 0);
        check("rst_arready", arready_a, 1);
        @(negedge clk); resetn = 1'b1;

        // mtime counts every clk with TICK_DIV=1.
        repeat (10) @(posedge clk);
        axi_read(BASE + 32'hBFF8, d, r, acc);
        check("mtime_rresp", r, 2'b00);
        check("mtime_10_12", (d >= 32'd10 && d <= 32'd12), 1);
        d_prev = d;
        axi_read(BASE + 32'hBFF8, d, r, acc);
        check("mtime_incr", d > d_prev, 1);

        // mtimecmp[0]=20 against a freshly zeroed mtime.
        axi_write(BASE + 32'h4000, 32'd20, 4'hF, r, acc);
        check("cmp_lo_bresp", r, 2'b00);
        axi_write(BASE + 32'hBFF8, 32'd0, 4'hF, r, c0);
        axi_write(BASE + 32'h4004, 32'd0, 4'hF, r, acc);
        check("mtip0_early", mtip_a[0], 0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("mtip0_vs_time", mtip_a[0], (cyc - c0) >= 20);
        end
        check("mtip1_idle", mtip_a[1], 0);
        axi_write(BASE + 32'h4004, 32'd1, 4'hF, r, acc);
        check("mtip0_drop", mtip_a[0], 0);
        axi_read(BASE + 32'h4004, d, r, acc);
        check("cmp_hi_read", d, 32'd1);

        // msip per hart, strobe handling.
        axi_write(BASE + 32'h0004, 32'd1, 4'hF, r, acc);
        check("msip_set1", msip_a, 2'b10);
        axi_write(BASE + 32'h0004, 32'd0, 4'h0, r, acc);
        check("msip_strb0", msip_a, 2'b10);
        check("msip_strb0_bresp", r, 2'b00);
        axi_write(BASE + 32'h0000, 32'hFFFF_FFFF, 4'b0010, r, acc);
        check("msip_byte1_only", msip_a, 2'b10);
        axi_read(BASE + 32'h0004, d, r, acc);
        check("msip1_read", d, 32'd1);
        axi_read(BASE + 32'h0000, d, r, acc);
        check("msip0_read", d, 32'd0);

        // Unmapped accesses.
        axi_read(BASE + 32'h1000, d, r, acc);
        check("unm_1000_rresp", r, 2'b10);
        check("unm_1000_rdata", d, 32'd0);
        axi_read(BASE + 32'h0008, d, r, acc);
        check("unm_0008_rresp", r, 2'b10);
        check("unm_0008_rdata", d, 32'd0);
        axi_read(BASE + 32'h4010, d, r, acc);
        check("unm_cmp2_rresp", r, 2'b10);
        axi_read(32'h0300_0000, d, r, acc);
        check("unm_window_rresp", r, 2'b10);
        axi_write(BASE + 32'h1000, 32'hFFFF_FFFF, 4'hF, r, acc);
        check("unm_wr_bresp", r, 2'b10);
        check("unm_wr_msip", msip_a, 2'b10);

        // Back-pressure on the write response.
        @(negedge clk);
        awaddr = BASE; wdata = 32'd1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        wdata = 32'd0;
        check("bp_bvalid_rise", bvalid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_bvalid_hold", bvalid, 1);
            check("bp_awready", awready, 0);
            check("bp_wready", wready, 0);
        end
        check("bp_msip_first", msip_a, 2'b11);
        @(negedge clk); bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check("bp_bvalid_clr", bvalid, 0);
        check("bp_msip_not_yet", msip_a, 2'b11);
        check("bp_awready_2nd", awready, 1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        check("bp_bvalid_2nd", bvalid, 1);
        check("bp_msip_second", msip_a, 2'b10);
        @(negedge clk); bready = 1'b1;
        @(posedge clk); #1; bready = 1'b0;

        // Instance B, TICK_DIV=4: 32-bit carry out of mtime lo.
        sel = 1'b1;
        axi_write(BASE + 32'hBFF8, 32'hFFFF_FFFF, 4'hF, r, acc);
        axi_write(BASE + 32'hBFFC, 32'h0, 4'hF, r, c0);
        check("b_mtip_low", mtip_b, 0);
        repeat (4) @(posedge clk);
        axi_read(BASE + 32'hBFFC, d, r, acc);
        model = 64'h0000_0000_FFFF_FFFF + 64'((acc - 1 - c0) / 4);
        check("b_hi_model", d, model[63:32]);
        check("b_hi_is_1", d, 32'd1);
        axi_read(BASE + 32'hBFF8, d, r, acc);
        model = 64'h0000_0000_FFFF_FFFF + 64'((acc - 1 - c0) / 4);
        check("b_lo_model", d, model[31:0]);
        check("b_lo_is_0", d, 32'd0);

        // 64-bit wrap; all-ones mtime meets the all-ones reset compare.
        axi_write(BASE + 32'hBFF8, 32'hFFFF_FFFF, 4'hF, r, acc);
        axi_write(BASE + 32'hBFFC, 32'hFFFF_FFFF, 4'hF, r, c0);
        check("b_mtip_max", mtip_b, 1);
        repeat (4) @(posedge clk);
        axi_read(BASE + 32'hBFFC, d, r, acc);
        model = 64'hFFFF_FFFF_FFFF_FFFF + 64'((acc - 1 - c0) / 4);
        check("b_wrap_hi", d, model[63:32]);
        check("b_mtip_wrap", mtip_b, 0);

        // Asynchronous reset with a read response pending.
        @(negedge clk);
        araddr = BASE + 32'hBFF8; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("rst_mid_rvalid_pre", rvalid, 1);
        #2 resetn = 1'b0;
        #1;
        check("rst_mid_rvalid", rvalid, 0);
        check("rst_mid_rdata", rdata, 0);
        @(negedge clk); resetn = 1'b1; c0 = cyc;
        axi_read(BASE + 32'hBFF8, d, r, acc);
        check("rst_mid_mtime", d, 32'((acc - 1 - c0) / 4));
        check("rst_mid_mtime0", d, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
